// File: rtl/display_n_digits.sv
// Free-running binary to seven-segment converter: serial double-dabble into a
// BCD register, then registered segment patterns with leading-zero blanking
// and an overflow indication when the value does not fit in DIGITS digits.
module display_n_digits #(
  parameter int WIDTH         = 11,
  parameter int DIGITS        = 4,
  parameter int BLANK_LEADING = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WIDTH-1:0]       value,
  output logic [DIGITS-1:0][6:0] displays,
  output logic                   done,
  output logic                   overflow
);

  localparam int unsigned NB_MIN = (WIDTH + 2) / 3;
  localparam int unsigned NB     = (DIGITS > int'(NB_MIN)) ? DIGITS : NB_MIN;
  localparam int unsigned BW     = 4 * NB;
  localparam int unsigned CW     = $clog2(WIDTH + 1);

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  typedef enum logic [1:0] {LOAD, SHIFT, DONE} state_t;

  state_t                  state, state_nx;
  logic [WIDTH-1:0]        shreg;
  logic [BW-1:0]           bcd;
  logic [BW-1:0]           bcd_adj_c;
  logic [BW-1:0]           bcd_nx_c;
  logic [CW-1:0]           cnt;
  logic [DIGITS-1:0][6:0]  disp_c;
  logic                    ovf_c;
  logic                    seen_c;
  logic [3:0]              dig_c;

  // Active-low segment pattern {g,f,e,d,c,b,a} for one BCD digit.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = SEG_BLANK;
    endcase
  endfunction

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= LOAD;
    else      state <= state_nx;
  end

  // Next-state logic: LOAD -> WIDTH x SHIFT -> DONE -> LOAD.
  always_comb begin
    state_nx = state;
    case (state)
      LOAD:    state_nx = SHIFT;
      SHIFT:   if (cnt == CW'(WIDTH - 1)) state_nx = DONE;
      DONE:    state_nx = LOAD;
      default: state_nx = LOAD;
    endcase
  end

  // Double-dabble step: add 3 to every digit >= 5, then shift in the next bit.
  always_comb begin
    bcd_adj_c = '0;
    for (int i = 0; i < int'(NB); i++) begin
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj_c[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      else                       bcd_adj_c[4*i +: 4] = bcd[4*i +: 4];
    end
    // The adjusted top bit is always zero for a correctly sized BCD register.
    bcd_nx_c = BW'({bcd_adj_c, shreg[WIDTH-1]});
  end

  // Conversion datapath: capture, shift, count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shreg <= '0;
      bcd   <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        LOAD: begin
          shreg <= value;
          bcd   <= '0;
          cnt   <= '0;
        end
        SHIFT: begin
          shreg <= {shreg[WIDTH-2:0], 1'b0};
          bcd   <= bcd_nx_c;
          cnt   <= cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

  // Segment decode with overflow dashes and leading-zero blanking.
  always_comb begin
    disp_c = '1;
    ovf_c  = 1'b0;
    seen_c = 1'b0;
    dig_c  = '0;
    for (int i = DIGITS; i < int'(NB); i++) begin
      if (bcd[4*i +: 4] != 4'd0) ovf_c = 1'b1;
    end
    for (int i = DIGITS - 1; i >= 0; i--) begin
      dig_c = bcd[4*i +: 4];
      if (dig_c != 4'd0 || i == 0) seen_c = 1'b1;
      if (ovf_c)                               disp_c[i] = SEG_DASH;
      else if (BLANK_LEADING != 0 && !seen_c)  disp_c[i] = SEG_BLANK;
      else                                     disp_c[i] = seg7(dig_c);
    end
  end

  // Registered outputs, updated only in DONE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      displays <= '1;
      overflow <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= (state == DONE);
      if (state == DONE) begin
        displays <= disp_c;
        overflow <= ovf_c;
      end
    end
  end

endmodule
